// File: rtl/vec_center_lift_if.sv
// Handshake bundle for vec_center_lift.
// Input side: in_valid/in_ready with an N x W residue vector.
// Output side: out_valid/out_ready with an N x WW centered signed vector and an error flag.
// Modports: slave is the lifter, master is the surrounding producer/consumer.
interface vec_center_lift_if #(
    parameter int N  = 8,
    parameter int W  = 8,
    parameter int WW = 16
);
    logic                   in_valid;
    logic                   in_ready;
    logic [N-1:0][W-1:0]    in_vec;
    logic                   out_valid;
    logic                   out_ready;
    logic [N-1:0][WW-1:0]   out_vec;
    logic                   out_err;

    modport slave (
        input  in_valid, in_vec, out_ready,
        output in_ready, out_valid, out_vec, out_err
    );

    modport master (
        output in_valid, in_vec, out_ready,
        input  in_ready, out_valid, out_vec, out_err
    );
endinterface

// File: rtl/vec_center_lift.sv
// Centered lift of a vector of mod-Q residues into signed WW-bit values in
// (-Q/2, Q/2]. LANES slots are lifted per cycle over K = ceil(N/LANES) cycles.
// Ports:
//   clk    - clock, rising edge
//   rst_n  - asynchronous active-low reset; aborts any vector in flight
//   bus    - slave side of vec_center_lift_if (in/out valid-ready, vectors, error flag)
//   busy   - high while a vector is being processed or held for output
module vec_center_lift #(
    parameter int N     = 8,
    parameter int W     = 8,
    parameter int WW    = 2 * W,
    parameter int Q     = 17,
    parameter int LANES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    vec_center_lift_if.slave        bus,
    output logic                    busy
);
    localparam int K     = (N + LANES - 1) / LANES;
    localparam int CNT_W = $clog2(K + 1);

    localparam logic [W-1:0]     Q_W    = W'(Q);
    localparam logic [W-1:0]     HALF_W = W'(Q / 2);
    localparam logic [WW-1:0]    Q_WW   = WW'(Q);
    localparam logic [CNT_W-1:0] K_CNT  = CNT_W'(K);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                     state_reg, state_next;
    logic [CNT_W-1:0]           cnt_reg;
    logic [N-1:0][W-1:0]        in_vec_reg;
    logic [N-1:0][WW-1:0]       out_vec_reg;
    logic                       err_reg;

    // Lift results are registered before being scattered into out_vec, so the
    // compare/subtract path and the wide write-back mux sit in separate cycles.
    logic [LANES-1:0][WW-1:0]   lift_reg;
    logic [CNT_W-1:0]           lift_chunk_reg;
    logic                       lift_valid_reg;

    logic [LANES-1:0][WW-1:0]   lane_val;
    logic [LANES-1:0]           lane_err;

    logic accept;
    logic issue;
    logic drained;

    assign accept  = (state_reg == IDLE) && bus.in_valid;
    assign issue   = (state_reg == RUN) && (cnt_reg < K_CNT);
    // Counter reaches K once the last chunk is in the lift register; that
    // chunk lands in out_vec on the same edge that enters DONE.
    assign drained = (state_reg == RUN) && (cnt_reg == K_CNT);

    assign bus.in_ready  = (state_reg == IDLE);
    assign bus.out_valid = (state_reg == DONE);
    assign bus.out_vec   = out_vec_reg;
    assign bus.out_err   = err_reg;
    assign busy          = (state_reg != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept)        state_next = RUN;
            RUN:     if (drained)       state_next = DONE;
            DONE:    if (bus.out_ready) state_next = IDLE;
            default:                    state_next = IDLE;
        endcase
    end

    // Per-lane lifter. Lane gi of chunk c handles slot c*LANES+gi; lanes past
    // the end of a partial last chunk see zero, which lifts to zero without error.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [W-1:0]  x;
        logic [WW-1:0] val;
        logic          err;

        always_comb begin
            x = '0;
            for (int c = 0; c < K; c++) begin
                if (((c * LANES + gi) < N) && (cnt_reg == CNT_W'(c))) begin
                    x = in_vec_reg[(c * LANES + gi) % N];
                end
            end
        end

        always_comb begin
            err = 1'b0;
            val = '0;
            if (x >= Q_W) begin
                err = 1'b1;
            end else if (x <= HALF_W) begin
                // Even Q: x == Q/2 stays positive.
                val = {{(WW - W){1'b0}}, x};
            end else begin
                val = {{(WW - W){1'b0}}, x} - Q_WW;
            end
        end

        assign lane_val[gi] = val;
        assign lane_err[gi] = err;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg    <= '0;
            in_vec_reg <= '0;
        end else if (accept) begin
            cnt_reg    <= '0;
            in_vec_reg <= bus.in_vec;
        end else if (issue) begin
            cnt_reg    <= cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lift_reg       <= '0;
            lift_chunk_reg <= '0;
            lift_valid_reg <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            lift_valid_reg <= issue;
            if (accept) begin
                err_reg <= 1'b0;
            end
            if (issue) begin
                lift_reg       <= lane_val;
                lift_chunk_reg <= cnt_reg;
                if (|lane_err) begin
                    err_reg <= 1'b1;
                end
            end
        end
    end

    // Scatter the registered chunk into its slots; untouched slots keep their value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vec_reg <= '0;
        end else if (lift_valid_reg) begin
            for (int i = 0; i < N; i++) begin
                if (lift_chunk_reg == CNT_W'(i / LANES)) begin
                    out_vec_reg[i] <= lift_reg[i % LANES];
                end
            end
        end
    end
endmodule

// File: tb/tb_vec_center_lift.sv
module tb_vec_center_lift;
    localparam int N  = 8;
    localparam int W  = 8;
    localparam int WW = 16;
    localparam int ND = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic [N-1:0][W-1:0] in_vec = '0;

    logic [ND-1:0] ov, ir, oe, bz;
    logic [N-1:0][WW-1:0] ovec [ND];

    // dut0: Q=17 LANES=3, dut1: Q=16 LANES=3, dut2: Q=17 LANES=1, dut3: Q=17 LANES=8
    int kexp [ND] = '{3, 3, 8, 1};
    int qd   [ND] = '{17, 16, 17, 17};
    int lat  [ND];

    int ntests = 0;
    int nfail  = 0;

    vec_center_lift_if #(.N(N), .W(W), .WW(WW)) ifs [ND] ();

    for (genvar gi = 0; gi < ND; gi++) begin : g_bus
        assign ifs[gi].in_valid  = in_valid;
        assign ifs[gi].in_vec    = in_vec;
        assign ifs[gi].out_ready = out_ready;
        assign ov[gi]   = ifs[gi].out_valid;
        assign ir[gi]   = ifs[gi].in_ready;
        assign oe[gi]   = ifs[gi].out_err;
        assign ovec[gi] = ifs[gi].out_vec;
    end

    vec_center_lift #(.N(N), .W(W), .WW(WW), .Q(17), .LANES(3)) u0 (
        .clk(clk), .rst_n(rst_n), .bus(ifs[0]), .busy(bz[0]));
    vec_center_lift #(.N(N), .W(W), .WW(WW), .Q(16), .LANES(3)) u1 (
        .clk(clk), .rst_n(rst_n), .bus(ifs[1]), .busy(bz[1]));
    vec_center_lift #(.N(N), .W(W), .WW(WW), .Q(17), .LANES(1)) u2 (
        .clk(clk), .rst_n(rst_n), .bus(ifs[2]), .busy(bz[2]));
    vec_center_lift #(.N(N), .W(W), .WW(WW), .Q(17), .LANES(8)) u3 (
        .clk(clk), .rst_n(rst_n), .bus(ifs[3]), .busy(bz[3]));

    always #5 clk = ~clk;

    typedef struct {
        int                    dut;
        logic [N-1:0][W-1:0]   vin;
        logic [N-1:0][WW-1:0]  vexp;
        logic                  exp_err;
        string                 name;
    } vec_rec_t;

    vec_rec_t tab [8];

    function automatic logic [N-1:0][W-1:0] vin8(input int a0, a1, a2, a3, a4, a5, a6, a7);
        logic [N-1:0][W-1:0] r;
        r[0] = 8'(a0); r[1] = 8'(a1); r[2] = 8'(a2); r[3] = 8'(a3);
        r[4] = 8'(a4); r[5] = 8'(a5); r[6] = 8'(a6); r[7] = 8'(a7);
        return r;
    endfunction

    function automatic logic [N-1:0][WW-1:0] vex8(input int a0, a1, a2, a3, a4, a5, a6, a7);
        logic [N-1:0][WW-1:0] r;
        r[0] = 16'(a0); r[1] = 16'(a1); r[2] = 16'(a2); r[3] = 16'(a3);
        r[4] = 16'(a4); r[5] = 16'(a5); r[6] = 16'(a6); r[7] = 16'(a7);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Present one vector, then wait until every instance shows out_valid and
    // check each instance's latency from the handshake edge.
    task automatic send_wait(input logic [N-1:0][W-1:0] v);
        logic [ND-1:0] found;
        @(negedge clk);
        chk("in_ready_idle", 128'(ir), 128'(4'hF));
        in_vec   = v;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_vec   = {$urandom, $urandom};
        found    = '0;
        for (int d = 0; d < ND; d++) lat[d] = -1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(posedge clk);
            #1;
            for (int d = 0; d < ND; d++) begin
                if (!found[d] && ov[d]) begin
                    found[d] = 1'b1;
                    lat[d]   = cyc;
                end
            end
            if (&found) break;
        end
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("latency_dut%0d", d), 128'(lat[d]), 128'(kexp[d] + 1));
        end
    endtask

    task automatic release_out();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("out_valid_drop", 128'(ov), 128'(0));
        chk("busy_drop", 128'(bz), 128'(0));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [N-1:0][W-1:0] v;
        logic seen;
        logic has16;
        int s, x, r, q;

        tab[0] = '{0, vin8(0, 1, 8, 9, 16, 5, 12, 3),   vex8(0, 1, 8, -8, -1, 5, -5, 3),   1'b0, "basic_q17"};
        tab[1] = '{1, vin8(8, 9, 15, 0, 7, 8, 1, 14),   vex8(8, -7, -1, 0, 7, 8, 1, -2),   1'b0, "even_q16"};
        tab[2] = '{0, vin8(3, 17, 255, 0, 0, 0, 0, 0),  vex8(3, 0, 0, 0, 0, 0, 0, 0),      1'b1, "err_q17"};
        tab[3] = '{0, vin8(16, 15, 9, 8, 1, 0, 2, 10),  vex8(-1, -2, -8, 8, 1, 0, 2, -7),  1'b0, "clean_after_err"};
        tab[4] = '{2, vin8(0, 1, 8, 9, 16, 5, 12, 3),   vex8(0, 1, 8, -8, -1, 5, -5, 3),   1'b0, "basic_l1"};
        tab[5] = '{3, vin8(0, 1, 8, 9, 16, 5, 12, 3),   vex8(0, 1, 8, -8, -1, 5, -5, 3),   1'b0, "basic_l8"};
        tab[6] = '{0, vin8(0, 0, 0, 0, 0, 0, 0, 200),   vex8(0, 0, 0, 0, 0, 0, 0, 0),      1'b1, "err_last_slot"};
        tab[7] = '{1, vin8(16, 8, 9, 0, 0, 0, 0, 15),   vex8(0, 8, -7, 0, 0, 0, 0, -1),    1'b1, "err_q16"};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", 128'(ir), 128'(4'hF));
        chk("reset_out_valid", 128'(ov), 128'(0));
        chk("reset_out_err", 128'(oe), 128'(0));
        chk("reset_busy", 128'(bz), 128'(0));
        for (int d = 0; d < ND; d++) chk($sformatf("reset_out_vec%0d", d), ovec[d], '0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table
        for (int t = 0; t < 8; t++) begin
            send_wait(tab[t].vin);
            chk({tab[t].name, "_vec"}, ovec[tab[t].dut], tab[t].vexp);
            chk({tab[t].name, "_err"}, 128'(oe[tab[t].dut]), 128'(tab[t].exp_err));
            $display("[TB] vector %s dut%0d out_vec=%h err=%0b", tab[t].name, tab[t].dut,
                     ovec[tab[t].dut], oe[tab[t].dut]);
            release_out();
        end

        // Backpressure: hold DONE, pulse in_valid with junk, outputs must not move
        send_wait(tab[0].vin);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            in_valid = (k % 2 == 0);
            in_vec   = {$urandom, $urandom};
            @(posedge clk);
            #1;
            chk("bp_out_valid", 128'(ov), 128'(4'hF));
            chk("bp_in_ready", 128'(ir), 128'(0));
            chk("bp_out_vec", ovec[0], tab[0].vexp);
        end
        @(negedge clk);
        in_valid = 1'b0;
        release_out();
        send_wait(tab[3].vin);
        chk("bp_next_vec", ovec[0], tab[3].vexp);
        chk("bp_next_err", 128'(oe[0]), 128'(0));
        $display("[TB] vector backpressure_next out_vec=%h", ovec[0]);
        release_out();

        // Asynchronous reset in the middle of RUN
        @(negedge clk);
        in_vec   = tab[0].vin;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("abort_in_ready", 128'(ir), 128'(4'hF));
        chk("abort_out_valid", 128'(ov), 128'(0));
        chk("abort_busy", 128'(bz), 128'(0));
        chk("abort_out_err", 128'(oe), 128'(0));
        for (int d = 0; d < ND; d++) chk($sformatf("abort_out_vec%0d", d), ovec[d], '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (15) begin
            @(posedge clk);
            #1;
            seen = seen | (|ov);
        end
        chk("abort_no_valid", 128'(seen), 128'(0));
        $display("[TB] vector abort_mid_run out_valid_seen=%0b", seen);

        // Random residues: round trip, centered range, error flag, latency
        for (int it = 0; it < 1000; it++) begin
            has16 = 1'b0;
            for (int i = 0; i < N; i++) begin
                v[i] = 8'($urandom_range(0, 16));
                if (v[i] == 8'd16) has16 = 1'b1;
            end
            send_wait(v);
            for (int d = 0; d < ND; d++) begin
                q = qd[d];
                for (int i = 0; i < N; i++) begin
                    s = int'($signed(ovec[d][i]));
                    x = int'(v[i]);
                    if (x < q) begin
                        r = ((s % q) + q) % q;
                        if (!((2 * s > -q) && (2 * s <= q))) r = -1;
                        chk($sformatf("roundtrip_dut%0d_slot%0d", d, i), 128'(r), 128'(x));
                    end else begin
                        chk($sformatf("errslot_dut%0d_slot%0d", d, i), 128'(s), 128'(0));
                    end
                end
                chk($sformatf("rand_err_dut%0d", d), 128'(oe[d]), 128'((d == 1) && has16));
            end
            $display("[TB] random %0d in=%h out0=%h err=%b", it, v, ovec[0], oe);
            release_out();
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
